// File: rtl/motor_pwm_gen.sv
// Per-motor PWM generator: ramp-limited duty, boundary-sampled speed/direction,
// and a brake -> dead-time -> flip sequence whenever the requested direction changes.
module motor_pwm_gen #(
    parameter int PRESCALE     = 4,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] duty_in,
    input  logic       dir_in,
    output logic       pwm_out,
    output logic       dir_out,
    output logic [6:0] duty_active,
    output logic       period_start,
    output logic       reversing
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_PERIODS);
    localparam logic [7:0]    STEP      = 8'(RAMP_STEP);
    localparam logic [6:0]    CNT_MAX   = 7'd126;

    typedef enum logic [1:0] {IDLE, RUN, BRAKE, DEAD} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [6:0]    pwm_cnt;
    logic [DW-1:0] dead_cnt;
    logic          pending_dir;
    logic          tick;
    logic          boundary;
    logic [7:0]    cur;
    logic [7:0]    tgt;
    logic [7:0]    ramp_val;
    logic [7:0]    brake_val;

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (pwm_cnt == CNT_MAX);
    assign cur      = {1'b0, duty_active};
    assign tgt      = duty_in & 8'h7F;

    // Move toward target by at most STEP; landing exactly on target avoids overshoot.
    always_comb begin
        brake_val = (cur > STEP) ? cur - STEP : 8'd0;
        if (tgt > cur)
            ramp_val = (tgt - cur > STEP) ? cur + STEP : tgt;
        else
            ramp_val = (cur - tgt > STEP) ? cur - STEP : tgt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            presc        <= '0;
            pwm_cnt      <= '0;
            dead_cnt     <= '0;
            pending_dir  <= 1'b0;
            pwm_out      <= 1'b0;
            dir_out      <= 1'b0;
            duty_active  <= '0;
            period_start <= 1'b0;
            reversing    <= 1'b0;
        end else if (!enable) begin
            // dir_out is deliberately kept: the motor still turns the last applied way.
            state        <= IDLE;
            presc        <= '0;
            pwm_cnt      <= '0;
            dead_cnt     <= '0;
            pending_dir  <= 1'b0;
            pwm_out      <= 1'b0;
            duty_active  <= '0;
            period_start <= 1'b0;
            reversing    <= 1'b0;
        end else if (state == IDLE) begin
            state        <= RUN;
            presc        <= '0;
            pwm_cnt      <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            pwm_out      <= ((state == RUN) || (state == BRAKE)) && (pwm_cnt < duty_active);
            if (tick) begin
                presc   <= '0;
                pwm_cnt <= (pwm_cnt == CNT_MAX) ? 7'd0 : pwm_cnt + 7'd1;
            end else begin
                presc   <= presc + PW'(1);
            end
            if (boundary) begin
                case (state)
                    RUN: begin
                        if (dir_in != dir_out) begin
                            pending_dir <= dir_in;
                            reversing   <= 1'b1;
                            if (duty_active == 7'd0) begin
                                state    <= DEAD;
                                dead_cnt <= DEAD_LOAD;
                            end else begin
                                state       <= BRAKE;
                                duty_active <= brake_val[6:0];
                            end
                        end else begin
                            duty_active <= ramp_val[6:0];
                        end
                    end
                    BRAKE: begin
                        if (duty_active == 7'd0) begin
                            state    <= DEAD;
                            dead_cnt <= DEAD_LOAD;
                        end else begin
                            duty_active <= brake_val[6:0];
                        end
                    end
                    DEAD: begin
                        if (dead_cnt <= DW'(1)) begin
                            dead_cnt  <= '0;
                            dir_out   <= pending_dir;
                            state     <= RUN;
                            reversing <= 1'b0;
                        end else begin
                            dead_cnt <= dead_cnt - DW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_motor_pwm_gen.sv
// Bench for motor_pwm_gen: two instances (PRESCALE 1 and 4) checked every clock against
// a time-based reference model, plus directed checks of ramp, reversal, stop and reset.
module tb_motor_pwm_gen;
    logic       clk = 1'b0;
    logic       rst_n, enable, dir_in;
    logic [7:0] duty_in;
    logic       pwm1, dir1, ps1, rev1;
    logic [6:0] duty1;
    logic       pwm4, dir4, ps4, rev4;
    logic [6:0] duty4;

    always #5 clk = ~clk;

    motor_pwm_gen #(.PRESCALE(1), .RAMP_STEP(8), .DEAD_PERIODS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .duty_in(duty_in), .dir_in(dir_in),
        .pwm_out(pwm1), .dir_out(dir1), .duty_active(duty1), .period_start(ps1), .reversing(rev1)
    );
    motor_pwm_gen #(.PRESCALE(4), .RAMP_STEP(8), .DEAD_PERIODS(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .duty_in(duty_in), .dir_in(dir_in),
        .pwm_out(pwm4), .dir_out(dir4), .duty_active(duty4), .period_start(ps4), .reversing(rev4)
    );

    localparam int STEP  = 8;
    localparam int DEADP = 2;

    // Model: mode 0 idle, 1 run, 2 brake, 3 dead; tt = clocks since the run started.
    int md[2], tt[2], dy[2], dv[2], pd[2], dc[2];
    bit e_pwm[2], e_ps[2];
    int n_tests = 0;
    int n_fail  = 0;
    int hi, len;

    function automatic int psc(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [10:0] act(int i);
        return (i == 0) ? {pwm1, dir1, duty1, ps1, rev1} : {pwm4, dir4, duty4, ps4, rev4};
    endfunction

    function automatic logic [10:0] expv(int i);
        logic rv;
        rv = (md[i] == 2) || (md[i] == 3);
        return {e_pwm[i], 1'(dv[i]), 7'(dy[i]), e_ps[i], rv};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            md[i] = 0; tt[i] = 0; dy[i] = 0; dv[i] = 0; pd[i] = 0; dc[i] = 0;
            e_pwm[i] = 1'b0; e_ps[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int per, ph, cnt, tgt;
        tgt = int'(duty_in & 8'h7F);
        for (int i = 0; i < 2; i++) begin
            if (!enable) begin
                md[i] = 0; dy[i] = 0; tt[i] = 0; e_pwm[i] = 1'b0; e_ps[i] = 1'b0;
            end else if (md[i] == 0) begin
                md[i] = 1; tt[i] = 0; e_pwm[i] = 1'b0; e_ps[i] = 1'b0;
            end else begin
                per      = 127 * psc(i);
                ph       = tt[i] % per;
                cnt      = ph / psc(i);
                e_pwm[i] = ((md[i] == 1) || (md[i] == 2)) && (cnt < dy[i]);
                e_ps[i]  = (ph == per - 1);
                if (e_ps[i]) begin
                    case (md[i])
                        1: begin
                            if (int'(dir_in) != dv[i]) begin
                                pd[i] = int'(dir_in);
                                if (dy[i] == 0) begin md[i] = 3; dc[i] = DEADP; end
                                else begin dy[i] -= min2(STEP, dy[i]); md[i] = 2; end
                            end else if (tgt > dy[i]) dy[i] += min2(STEP, tgt - dy[i]);
                            else dy[i] -= min2(STEP, dy[i] - tgt);
                        end
                        2: begin
                            if (dy[i] == 0) begin md[i] = 3; dc[i] = DEADP; end
                            else dy[i] -= min2(STEP, dy[i]);
                        end
                        3: begin
                            dc[i]--;
                            if (dc[i] == 0) begin dv[i] = pd[i]; md[i] = 1; end
                        end
                        default: ;
                    endcase
                end
                tt[i]++;
            end
        end
    endtask

    task automatic cyc();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        chk($sformatf("cyc_dut1@%0t", $time), 16'(act(0)), 16'(expv(0)));
        chk($sformatf("cyc_dut4@%0t", $time), 16'(act(1)), 16'(expv(1)));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_ps(input int i);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            cyc();
            if (((i == 0) ? ps1 : ps4) === 1'b1) seen = 1'b1;
        end
        chk($sformatf("wait_ps%0d", i), 16'(seen), 16'd1);
    endtask

    // Call right after a period_start pulse; counts high clocks until the next pulse.
    task automatic count_period(input int i, output int h, output int l);
        h = 0;
        l = 0;
        do begin
            cyc();
            l++;
            if (((i == 0) ? pwm1 : pwm4) === 1'b1) h++;
        end while ((((i == 0) ? ps1 : ps4) !== 1'b1) && (l < 2000));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; dir_in = 1'b0; duty_in = 8'h00;
        model_reset();
        #3;
        chk("reset_dut1", 16'(act(0)), 16'd0);
        chk("reset_dut4", 16'(act(1)), 16'd0);
        run(3);
        rst_n = 1'b1;
        run(4);
        chk("idle_pwm", 16'(pwm1), 16'd0);

        // ramp up to 64
        enable = 1'b1; duty_in = 8'h40;
        for (int k = 1; k <= 8; k++) begin
            wait_ps(0);
            chk($sformatf("ramp_%0d", k), 16'(duty1), 16'(8 * k));
        end
        count_period(0, hi, len);
        chk("high_64", 16'(hi), 16'd64);
        chk("period_127", 16'(len), 16'd127);

        // bit 7 ignored, then full scale
        duty_in = 8'hC0;
        wait_ps(0);
        chk("msb_ignored", 16'(duty1), 16'd64);
        duty_in = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            wait_ps(0);
            chk($sformatf("ramp_hi_%0d", k), 16'(duty1), 16'(min2(64 + 8 * k, 127)));
        end
        count_period(0, hi, len);
        chk("high_127", 16'(hi), 16'd127);

        // reversal from duty 16
        duty_in = 8'd16;
        for (int k = 0; k < 16; k++) wait_ps(0);
        chk("duty_16", 16'(duty1), 16'd16);
        run(30);
        dir_in = 1'b1;
        run(30);
        chk("midper_duty", 16'(duty1), 16'd16);
        chk("midper_rev", 16'(rev1), 16'd0);
        wait_ps(0);
        chk("b1_duty", 16'(duty1), 16'd8);
        chk("b1_rev", 16'(rev1), 16'd1);
        wait_ps(0);
        chk("b2_duty", 16'(duty1), 16'd0);
        wait_ps(0);
        chk("b3_rev", 16'(rev1), 16'd1);
        wait_ps(0);
        chk("b4_dir", 16'(dir1), 16'd0);
        count_period(0, hi, len);
        chk("dead_high", 16'(hi), 16'd0);
        chk("b5_dir", 16'(dir1), 16'd1);
        chk("b5_rev", 16'(rev1), 16'd0);
        wait_ps(0);
        chk("b6_duty", 16'(duty1), 16'd8);

        // enable drop mid-period
        duty_in = 8'd64;
        for (int k = 0; k < 7; k++) wait_ps(0);
        chk("duty_64", 16'(duty1), 16'd64);
        run(40);
        enable = 1'b0;
        cyc();
        chk("stop_pwm", 16'(pwm1), 16'd0);
        chk("stop_duty", 16'(duty1), 16'd0);
        chk("stop_dir", 16'(dir1), 16'd1);
        run(5);
        enable = 1'b1;
        wait_ps(0);
        chk("restart_duty", 16'(duty1), 16'd8);

        // asynchronous reset mid-clock
        run(50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dut1", 16'(act(0)), 16'd0);
        chk("async_rst_dut4", 16'(act(1)), 16'd0);
        model_reset();
        dir_in = 1'b0; duty_in = 8'd1;
        run(2);
        rst_n = 1'b1;

        // PRESCALE=4: duty 1 then 0
        wait_ps(1);
        chk("p4_duty1", 16'(duty4), 16'd1);
        count_period(1, hi, len);
        chk("p4_high4", 16'(hi), 16'd4);
        chk("p4_period", 16'(len), 16'd508);
        duty_in = 8'd0;
        wait_ps(1);
        count_period(1, hi, len);
        chk("p4_high0", 16'(hi), 16'd0);

        // randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            duty_in = 8'($urandom);
            if ($urandom_range(0, 3) == 0) dir_in = ~dir_in;
            enable = ($urandom_range(0, 11) != 0);
            run($urandom_range(1, 400));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
